// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader and the CPU blocks:
//   loader state encoding, instruction word width and byte-lane constants.
package imem_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  // Big-endian lane order: lane 0 is the first byte received and lands in
  // [31:24]; lane 3 is the last byte and lands in [7:0].
  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Shifting each new byte in at the bottom leaves the first byte in the top
  // lane once a whole word has arrived.
  function automatic logic [WORD_W-1:0] shift_in_byte(input logic [WORD_W-1:0] w,
                                                      input logic [BYTE_W-1:0] b);
    return {w[WORD_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Load-control, byte-stream and instruction-memory write signals of the
//   loader.
//   slave  : loader side (start/load_len/byte stream in; ready, write port,
//            cpu_hold, done, chk_err out)
//   master : host / byte source side (mirror of slave)
interface imem_loader_if #(parameter int ADDR_W = 8);

  logic              start;
  logic [5:0]        load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              chk_err;

  modport slave (
    input  start, load_len, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, chk_err
  );

  modport master (
    output start, load_len, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, chk_err
  );

endinterface

// File: rtl/imem_word_packer.sv
// imem_word_packer
//   Byte shift register plus byte index that assembles four stream bytes
//   into one big-endian instruction word.
//   clk, reset : clock, async active-high reset
//   clear      : restart assembly at lane 0
//   shift_en   : accept byte_in this cycle
//   byte_in    : incoming program byte
//   word_nxt   : word as it will be after this cycle's shift
//   last_byte  : this cycle's shift completes a word
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_nxt,
  output logic              last_byte
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = LANE_FIRST;
    end else if (shift_en) begin
      word_d = shift_in_byte(word_q, byte_in);
      idx_d  = idx_q + 2'd1;  // wraps back to lane 0 after the 4th byte
    end
  end

  assign word_nxt  = word_d;
  assign last_byte = shift_en && !clear && (idx_q == LANE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= LANE_FIRST;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Loads a program from a byte stream into instruction memory while holding
//   the CPU, then checks a trailing XOR checksum byte.
//   clk   : clock
//   reset : async active-high reset
//   bus   : imem_loader_if.slave (start/load_len, byte stream, memory write
//           port, cpu_hold, done, chk_err)
//
//   state    | meaning
//   IDLE     | waiting for start, CPU runs
//   RECV     | accepting program bytes into the packer
//   WRITE    | one-cycle memory write of the assembled word
//   CHECK    | accepting the checksum byte
//   DONE     | one-cycle done pulse
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic           clk,
  input logic           reset,
  imem_loader_if.slave  bus
);

  state_e            state_q, state_d;
  logic [6:0]        len_q, len_d;        // 1..64 words
  logic [6:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        xor_q, xor_d;
  logic              chk_err_q, chk_err_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;

  logic              accept;
  logic              pk_clear;
  logic              pk_shift;
  logic [WORD_W-1:0] pk_word_nxt;
  logic              pk_last;

  assign accept   = bus.byte_valid && byte_ready_q;
  assign pk_clear = (state_q == ST_IDLE) && bus.start;
  assign pk_shift = (state_q == ST_RECV) && accept;

  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .byte_in   (bus.byte_data),
    .word_nxt  (pk_word_nxt),
    .last_byte (pk_last)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    xor_d     = xor_q;
    chk_err_d = chk_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // A length field of 0 encodes 64 words.
          len_d   = {(bus.load_len == 6'd0), bus.load_len};
          cnt_d   = '0;
          addr_d  = '0;
          xor_d   = '0;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (accept) begin
          xor_d = xor_q ^ bus.byte_data;
          if (pk_last) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_W'(BYTES_PER_WORD);
        cnt_d   = cnt_q + 7'd1;
        state_d = (cnt_q + 7'd1 == len_q) ? ST_CHECK : ST_RECV;
      end
      ST_CHECK: begin
        if (accept) begin
          chk_err_d = (bus.byte_data != xor_q);
          state_d   = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    byte_ready_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
    mem_we_d     = (state_d == ST_WRITE);
    cpu_hold_d   = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    mem_wdata_d  = mem_wdata_q;
    if (pk_shift && pk_last) mem_wdata_d = pk_word_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      xor_q        <= '0;
      chk_err_q    <= 1'b0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      xor_q        <= xor_d;
      chk_err_q    <= chk_err_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.chk_err    = chk_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Randomized bench for imem_loader with a word-level reference model:
//   expected writes are word i at address 4*i (mod 256) holding bytes
//   4i..4i+3 big-endian; chk_err is (checksum byte != XOR of program bytes).
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  prog [256];
  logic [39:0] wq [$];   // observed writes {addr, data}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wq.push_back({bus.mem_addr, bus.mem_wdata});
      check("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
    end
  end

  // gap: 0 = always valid, 1 = toggle every cycle, 2 = random
  task automatic run_load(input string tag, input int nwords, input int gap,
                          input int restart_at, input bit use_chk, input logic [7:0] chk_val);
    logic [7:0]  xr;
    logic [7:0]  chk;
    logic [31:0] w;
    int nbytes, k, cyc, phase;
    bit v, rdy, seen, pulsed;
    xr = 8'h00;
    nbytes = nwords * 4;
    for (int i = 0; i < nbytes; i++) xr ^= prog[i];
    chk = use_chk ? chk_val : xr;
    wq.delete();

    @(negedge clk);
    bus.start = 1'b1;
    bus.load_len = 6'(nwords);
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; cyc = 0; phase = 1; pulsed = 0;
    while (k <= nbytes && cyc < 5000) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? phase[0] : 1'($urandom_range(0, 1));
      phase ^= 1;
      rdy = bus.byte_ready;
      bus.byte_valid = v;
      bus.byte_data  = (k < nbytes) ? prog[k] : chk;
      if (!pulsed && rdy && k == restart_at && k < nbytes) begin
        bus.start = 1'b1;
        bus.load_len = 6'(nwords + 1);
        pulsed = 1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      if (v && rdy) k++;
      @(negedge clk);
      cyc++;
    end
    bus.byte_valid = 1'b0;
    bus.start = 1'b0;
    if (cyc >= 5000) check({tag, "_byte_timeout"}, 64'(k), 64'(nbytes + 1));

    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.done) seen = 1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_chk_err"}, 64'(bus.chk_err), 64'(chk != xr));
      check({tag, "_hold_in_done"}, 64'(bus.cpu_hold), 64'd1);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
      check({tag, "_hold_released"}, 64'(bus.cpu_hold), 64'd0);
    end

    check({tag, "_nwrites"}, 64'(wq.size()), 64'(nwords));
    for (int i = 0; i < nwords && i < wq.size(); i++) begin
      w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
      check({tag, "_waddr"}, 64'(wq[i][39:32]), 64'((4 * i) % 256));
      check({tag, "_wdata"}, 64'(wq[i][31:0]), 64'(w));
    end
    w = {prog[4*nwords-4], prog[4*nwords-3], prog[4*nwords-2], prog[4*nwords-1]};
    check({tag, "_addr_after"}, 64'(bus.mem_addr), 64'((4 * nwords) % 256));
    check({tag, "_wdata_hold"}, 64'(bus.mem_wdata), 64'(w));
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) prog[i] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.load_len = 6'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.byte_ready), 64'd0);
    check("rst_we",    64'(bus.mem_we), 64'd0);
    check("rst_hold",  64'(bus.cpu_hold), 64'd0);
    check("rst_done",  64'(bus.done), 64'd0);
    check("rst_err",   64'(bus.chk_err), 64'd0);
    check("rst_addr",  64'(bus.mem_addr), 64'd0);
    check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: single word with correct checksum
    prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h04;
    run_load("t1", 1, 0, -1, 1'b1, 8'h89);

    // Test 2: two words with a wrong checksum
    prog[0] = 8'h20; prog[1] = 8'h02; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'hAC; prog[5] = 8'h02; prog[6] = 8'h00; prog[7] = 8'h00;
    run_load("t2", 2, 0, -1, 1'b1, 8'h00);

    // Test 5: reset between 2nd and 3rd byte, then a fresh load
    fill_random(8);
    wq.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.load_len = 6'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data = prog[0];
    @(negedge clk);
    bus.byte_data = prog[1];
    @(negedge clk);
    bus.byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_ready", 64'(bus.byte_ready), 64'd0);
    check("arst_hold",  64'(bus.cpu_hold), 64'd0);
    check("arst_err",   64'(bus.chk_err), 64'd0);
    check("arst_wdata", 64'(bus.mem_wdata), 64'd0);
    check("arst_addr",  64'(bus.mem_addr), 64'd0);
    check("arst_we",    64'(bus.mem_we), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_write", 64'(wq.size()), 64'd0);
    fill_random(8);
    run_load("t5_fresh", 2, 2, -1, 1'b0, 8'h00);

    // Test 3: byte_valid toggling every cycle
    fill_random(12);
    run_load("t3", 3, 1, -1, 1'b0, 8'h00);

    // Test 4: load_len = 0 -> 64 words, address wraps
    fill_random(256);
    run_load("t4", 64, 0, -1, 1'b0, 8'h00);

    // Test 6: start pulsed during RECV is ignored
    fill_random(16);
    run_load("t6", 4, 0, 2, 1'b0, 8'h00);

    // Random loads
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(1, 64);
      fill_random(nw * 4);
      run_load("rnd", nw, 2, -1, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
